// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, default width and idle levels for the SPI responder
package spi_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} spi_state_t;
    localparam int SPI_W_LENGTH = 10;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic LOAD_IDLE = 1'b1;
    localparam logic SDI_IDLE = 1'b1;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins between SPI master and responder
interface spi_slave_if;
    logic sclk_in;
    logic sdi_in;
    logic load_in;
    logic sdo_out;
    modport master(output sclk_in, sdi_in, load_in, input sdo_out);
    modport slave(input sclk_in, sdi_in, load_in, output sdo_out);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchronizer with registered rise/fall flags aligned to level q
module spi_sync_edge #(
    parameter int stages = 2,
    parameter logic rst_lvl = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [stages-1:0] sync;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {stages{rst_lvl}};
            q    <= rst_lvl;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[stages-2:0], d};
            q    <= sync[stages-1];
            rise <= sync[stages-1] & ~q;
            fall <= ~sync[stages-1] & q;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder (idle-high sclk, active-low load, MSB first); SPI_SLAVE_FRAME_ERR_EN adds frame_err
module spi_slave import spi_pkg::*; #(
    parameter int w_length = SPI_W_LENGTH,
    parameter int sync_stages = 2,
    parameter bit inv_clk = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [w_length-1:0] value_in,
    input  logic                load_strob,
    output logic [w_length-1:0] value_out,
    output logic                valid,
    output logic                busy,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic                frame_err,
`endif
    spi_slave_if.slave          bus
);
    localparam int CW = cnt_width(w_length);
    localparam logic [CW-1:0] LAST = CW'(w_length - 1);

    spi_state_t state, state_n;
    logic [w_length-1:0] tx_buf, shift_tx, shift_tx_n, shift_rx, shift_rx_n, value_out_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic sdo, sdo_n, valid_n;
    logic sclk_q, sclk_rise, sclk_fall, load_q, load_rise, load_fall, sdi_q, sdi_rise, sdi_fall;
    logic unused_ok;

    spi_sync_edge #(.stages(sync_stages), .rst_lvl(SCLK_IDLE)) u_sclk (
        .clk(clk), .rst(rst), .d(inv_clk ? bus.sclk_in : ~bus.sclk_in),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.stages(sync_stages), .rst_lvl(LOAD_IDLE)) u_load (
        .clk(clk), .rst(rst), .d(bus.load_in),
        .q(load_q), .rise(load_rise), .fall(load_fall));
    spi_sync_edge #(.stages(sync_stages), .rst_lvl(SDI_IDLE)) u_sdi (
        .clk(clk), .rst(rst), .d(bus.sdi_in),
        .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));

    assign unused_ok = ^{sclk_q, load_q, sdi_rise, sdi_fall};
    assign busy = state != IDLE;
    assign bus.sdo_out = sdo;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic err_n, err_seen, err_seen_n;
`endif

    always_comb begin
        state_n     = state;
        shift_tx_n  = shift_tx;
        shift_rx_n  = shift_rx;
        bit_cnt_n   = bit_cnt;
        value_out_n = value_out;
        sdo_n       = sdo;
        valid_n     = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        err_n       = 1'b0;
        err_seen_n  = err_seen;
`endif
        case (state)
            IDLE: begin
                sdo_n = 1'b1;
                if (load_fall) begin
                    state_n    = ACTIVE;
                    shift_tx_n = tx_buf;
                    sdo_n      = tx_buf[w_length-1];
                    bit_cnt_n  = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    err_seen_n = 1'b0;
`endif
                end
            end
            ACTIVE: begin
                if (load_rise) begin
                    state_n = IDLE;
                    sdo_n   = 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    err_n   = bit_cnt != '0;
`endif
                end else if (sclk_rise) begin
                    shift_rx_n = {shift_rx[w_length-2:0], sdi_q};
                    bit_cnt_n  = bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
                        value_out_n = {shift_rx[w_length-2:0], sdi_q};
                        valid_n     = 1'b1;
                        state_n     = DONE;
                    end
                end else if (sclk_fall && bit_cnt != '0) begin
                    // the launch edge before the first sample keeps the preloaded MSB on sdo
                    shift_tx_n = shift_tx << 1;
                    sdo_n      = shift_tx[w_length-2];
                end
            end
            DONE: begin
                if (load_rise) begin
                    state_n = IDLE;
                    sdo_n   = 1'b1;
                end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                else if (sclk_rise && !err_seen) begin
                    err_n      = 1'b1;
                    err_seen_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_buf    <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            bit_cnt   <= '0;
            value_out <= '0;
            valid     <= 1'b0;
            sdo       <= 1'b1;
        end else begin
            state     <= state_n;
            tx_buf    <= load_strob ? value_in : tx_buf;
            shift_tx  <= shift_tx_n;
            shift_rx  <= shift_rx_n;
            bit_cnt   <= bit_cnt_n;
            value_out <= value_out_n;
            valid     <= valid_n;
            sdo       <= sdo_n;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_seen  <= 1'b0;
        end else begin
            frame_err <= err_n;
            err_seen  <= err_seen_n;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frames against a word-level model; dut1 sees inverted sclk with inv_clk=0
module tb_spi_slave;
    localparam int W = 10;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] value_in = '0;
    logic load_strob = 1'b0;
    logic [W-1:0] vo0, vo1;
    logic v0, v1, b0, b1;
    logic m_sclk = 1'b1, m_sdi = 1'b1, m_load = 1'b1;
    int n_checks = 0, n_fail = 0;
    int vcnt0 = 0, vcnt1 = 0, exp_v = 0;
    logic [W-1:0] tx_model = '0, exp_val = '0;

    always #5 clk = ~clk;

    spi_slave_if bus0();
    spi_slave_if bus1();
    assign bus0.sclk_in = m_sclk;
    assign bus0.sdi_in  = m_sdi;
    assign bus0.load_in = m_load;
    assign bus1.sclk_in = ~m_sclk;
    assign bus1.sdi_in  = m_sdi;
    assign bus1.load_in = m_load;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic fe0, fe1;
    int ecnt0 = 0, ecnt1 = 0, exp_e = 0;
    always @(negedge clk) begin
        if (fe0) ecnt0++;
        if (fe1) ecnt1++;
    end
`endif

    spi_slave #(.w_length(W), .sync_stages(2), .inv_clk(1'b1)) dut0 (
        .clk(clk), .rst(rst), .value_in(value_in), .load_strob(load_strob),
        .value_out(vo0), .valid(v0), .busy(b0),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(fe0),
`endif
        .bus(bus0));
    spi_slave #(.w_length(W), .sync_stages(2), .inv_clk(1'b0)) dut1 (
        .clk(clk), .rst(rst), .value_in(value_in), .load_strob(load_strob),
        .value_out(vo1), .valid(v1), .busy(b1),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err(fe1),
`endif
        .bus(bus1));

    always @(negedge clk) begin
        if (v0) vcnt0++;
        if (v1) vcnt1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (H) @(negedge clk);
    endtask

    task automatic strobe(input logic [W-1:0] val);
        value_in = val;
        load_strob = 1'b1;
        @(negedge clk);
        load_strob = 1'b0;
        tx_model = val;
    endtask

    // master side of one frame; reply word is whatever the buffer held when load fell
    task automatic frame(input logic [W-1:0] word, input int nclk, input int rst_at,
                         input int strobe_at, input logic [W-1:0] sval);
        logic [W-1:0] reply;
        logic exp_sdo;
        bit was_rst;
        reply = tx_model;
        was_rst = 0;
        m_load = 1'b0;
        half();
        for (int i = 0; i < nclk; i++) begin
            m_sclk = 1'b0;
            m_sdi = (i < W) ? word[W-1-i] : 1'($urandom);
            if (i == strobe_at) strobe(sval);
            half();
            if (i == rst_at) begin
                rst = 1'b1;
                m_load = 1'b1;
                m_sclk = 1'b1;
                m_sdi = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_busy0", 32'(b0), 0);
                check("rst_sdo0", 32'(bus0.sdo_out), 1);
                check("rst_vo0", 32'(vo0), 0);
                check("rst_busy1", 32'(b1), 0);
                was_rst = 1;
                break;
            end
            m_sclk = 1'b1;
            exp_sdo = (i < W) ? reply[W-1-i] : reply[0];
            check("sdo0", 32'(bus0.sdo_out), 32'(exp_sdo));
            check("sdo1", 32'(bus1.sdo_out), 32'(exp_sdo));
            if (i == 0) check("busy_mid0", 32'(b0), 1);
            half();
        end
        m_load = 1'b1;
        m_sdi = 1'b1;
        half();
        if (was_rst) begin
            exp_val = '0;
            tx_model = '0;
        end else if (nclk >= W) begin
            exp_val = word;
            exp_v++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (nclk > W) exp_e++;
`endif
        end else begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (nclk > 0) exp_e++;
`endif
        end
        check("value_out0", 32'(vo0), 32'(exp_val));
        check("value_out1", 32'(vo1), 32'(exp_val));
        check("valid_cnt0", vcnt0, exp_v);
        check("valid_cnt1", vcnt1, exp_v);
        check("busy_end0", 32'(b0), 0);
        check("busy_end1", 32'(b1), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err0", ecnt0, exp_e);
        check("frame_err1", ecnt1, exp_e);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_vo", 32'(vo0), 0);
        check("reset_valid", 32'(v0), 0);
        check("reset_busy", 32'(b0), 0);
        check("reset_sdo", 32'(bus0.sdo_out), 1);
        check("reset_sdo1", 32'(bus1.sdo_out), 1);
        half();
        strobe(10'h2A5);
        frame(10'h1C3, W, -1, -1, '0);
        frame(10'h3FF, W, -1, 3, 10'h155);
        frame(10'h000, W, -1, -1, '0);
        frame(10'h155, 4, -1, -1, '0);
        frame(10'h0F0, 12, -1, -1, '0);
        frame(10'h123, W, 5, -1, '0);
        frame(10'h2AA, W, -1, -1, '0);
        strobe(10'h0C7);
        frame(10'h3C1, W, -1, -1, '0);
        for (int k = 0; k < 20; k++) begin
            int r, n, s;
            r = $urandom_range(0, 9);
            n = (r < 6) ? W : (r < 8) ? $urandom_range(1, W - 1) : W + $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) strobe(W'($urandom));
            s = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            frame(W'($urandom), n, -1, s, W'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
